// File: rtl/gate_sweep_ctrl.sv
// Exhaustive sweep controller for an N_IN-input NOR gate: drives every input vector, samples y, counts mismatches.
// Optional first-failure capture is compiled in when GATE_SWEEP_FAIL_CAPTURE_EN is defined.
module gate_sweep_ctrl #(
  parameter int N_IN       = 2,
  parameter int SETTLE_CYC = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            y,
  output logic [N_IN-1:0] din,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic            fail_valid,
  output logic [N_IN-1:0] fail_vec
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam logic [N_IN-1:0] DIN_MAX     = '1;
  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE_CYC - 1);

  state_t     state;
  logic [3:0] settle_cnt;
  logic       mismatch;

  // Expected gate output is the NOR of the vector currently driven.
  assign mismatch = (y != ~|din);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      din        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          din  <= '0;
          if (start) begin
            state      <= SETTLE;
            settle_cnt <= '0;
            err_cnt    <= '0;
            busy       <= 1'b1;
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= CHECK;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        CHECK: begin
          if (mismatch) begin
            err_cnt <= err_cnt + (N_IN+1)'(1);
          end
          if (din == DIN_MAX) begin
            // pass must include the verdict of this final check
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            din   <= '0;
            pass  <= (err_cnt == '0) && !mismatch;
          end else begin
            state      <= SETTLE;
            settle_cnt <= '0;
            din        <= din + N_IN'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
  // Only the first mismatch of a sweep is recorded; cleared on the accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else if (state == IDLE && start) begin
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else if (state == CHECK && mismatch && !fail_valid) begin
      fail_valid <= 1'b1;
      fail_vec   <= din;
    end
  end
`else
  assign fail_valid = 1'b0;
  assign fail_vec   = '0;
`endif

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Randomized bench for gate_sweep_ctrl: a per-vector fault mask corrupts the NOR seen by the DUT,
// and a timing/arithmetic reference model predicts every output cycle by cycle.
module tb_gate_sweep_ctrl;
  localparam int N_IN = 3;
  localparam int S    = 2;
  localparam int NV   = 1 << N_IN;
  localparam int T    = NV * (S + 1);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            y;
  logic [N_IN-1:0] din;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_cnt;
  logic            fail_valid;
  logic [N_IN-1:0] fail_vec;
  logic [NV-1:0]   flip = '0;

  int n_tests = 0;
  int n_fail  = 0;

  int exp_pass = 0;
  int exp_err  = 0;
  int exp_fv   = 0;
  int exp_fvec = 0;

  gate_sweep_ctrl #(.N_IN(N_IN), .SETTLE_CYC(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .y(y), .din(din), .busy(busy),
    .done(done), .pass(pass), .err_cnt(err_cnt), .fail_valid(fail_valid), .fail_vec(fail_vec)
  );

  // Gate under control: a correct NOR, inverted on the vectors selected by flip.
  assign y = (~|din) ^ flip[din];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all(input string ph, input int d, input int b, input int dn, input int p,
                         input int e, input int fv, input int fvec);
    chk({ph, ".din"}, 32'(din), d);
    chk({ph, ".busy"}, 32'(busy), b);
    chk({ph, ".done"}, 32'(done), dn);
    chk({ph, ".pass"}, 32'(pass), p);
    chk({ph, ".err_cnt"}, 32'(err_cnt), e);
    chk({ph, ".fail_valid"}, 32'(fail_valid), fv);
    chk({ph, ".fail_vec"}, 32'(fail_vec), fvec);
  endtask

  // Mismatches already counted t cycles after the accepting edge.
  function automatic int errs_upto(input logic [NV-1:0] f, input int t);
    int n = 0;
    for (int k = 0; k < NV; k++)
      if (f[k] && (k + 1) * (S + 1) <= t) n++;
    return n;
  endfunction

  function automatic int first_fail(input logic [NV-1:0] f, input int t);
    for (int k = 0; k < NV; k++)
      if (f[k] && (k + 1) * (S + 1) <= t) return k;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b0;
      step();
      chk_all("idle", 0, 0, 0, exp_pass, exp_err, exp_fv, exp_fvec);
    end
  endtask

  // One sweep from an idle DUT. abort_t >= 0 pulls reset that many cycles after the accepting edge.
  task automatic sweep(input string ph, input logic [NV-1:0] f, input int abort_t);
    int e, ff, fv, fvec;
    flip  = f;
    start = 1'b1;
    for (int t = 0; t <= T + 1; t++) begin
      if (t > 0) start = ($urandom_range(0, 3) == 0);
      step();
      if (t == 0) start = 1'b0;
      if (t == abort_t) begin
        rst_n = 1'b0;
        #1;
        chk_all({ph, ".abort"}, 0, 0, 0, 0, 0, 0, 0);
        start = 1'b0;
        step();
        rst_n = 1'b1;
        exp_pass = 0; exp_err = 0; exp_fv = 0; exp_fvec = 0;
        return;
      end
      e  = errs_upto(f, t);
      ff = first_fail(f, t);
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
      fv   = (ff >= 0) ? 1 : 0;
      fvec = (ff >= 0) ? ff : 0;
`else
      fv   = 0;
      fvec = 0;
`endif
      if (t < T) begin
        chk_all({ph, ".run"}, t / (S + 1), 1, 0, exp_pass, e, fv, fvec);
      end else if (t == T) begin
        exp_pass = (e == 0) ? 1 : 0;
        chk_all({ph, ".done"}, 0, 0, 1, exp_pass, e, fv, fvec);
      end else begin
        chk_all({ph, ".after"}, 0, 0, 0, exp_pass, e, fv, fvec);
      end
      exp_err = e; exp_fv = fv; exp_fvec = fvec;
    end
    start = 1'b0;
  endtask

  initial begin
    logic [NV-1:0] f;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    idle_cycles(2);

    sweep("clean", '0, -1);
    idle_cycles(1);
    sweep("y_tied0", NV'(1), -1);
    idle_cycles(1);
    sweep("y_tied1", ~NV'(1), -1);
    idle_cycles(2);
    sweep("abort", NV'($urandom) | NV'(1), 2 * (S + 1) + 1);
    idle_cycles(1);
    chk_all("post_abort", 0, 0, 0, 0, 0, 0, 0);
    sweep("after_abort", '0, -1);
    sweep("b2b_faulty", NV'($urandom) | NV'(8'h10), -1);
    sweep("b2b_clean", '0, -1);

    for (int i = 0; i < 20; i++) begin
      f = NV'($urandom);
      if ($urandom_range(0, 3) == 0) f = '0;
      sweep("rand", f, -1);
      idle_cycles($urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule
